// File: rtl/tlul_host_arb2.sv
// Two-host to one-device TL-UL arbiter; holds each grant until its responses have drained.
// Optional build macro TLUL_ARB_LSU_PRIORITY_EN: host 1 (LSU) wins ties and bursts without limit.
package tlul_arb2_pkg;
    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;
endpackage

// state  | meaning
// IDLE   | no grant; pick the next host (one bubble per switch)
// GNT_H0 | host 0 (IF) owns the device port until drained
// GNT_H1 | host 1 (LSU) owns the device port until drained
module tlul_host_arb2
    import tlul_arb2_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned MaxBurst       = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  tl_h2d_t    tl_h0_i,
    output tl_d2h_t    tl_h0_o,
    input  tl_h2d_t    tl_h1_i,
    output tl_d2h_t    tl_h1_o,
    output tl_h2d_t    tl_dev_o,
    input  tl_d2h_t    tl_dev_i,
    output logic [1:0] grant_o
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_H0 = 2'd1,
        GNT_H1 = 2'd2
    } state_e;

    localparam logic [3:0] MAX_OUT   = 4'(MaxOutstanding);
    localparam logic [3:0] MAX_BURST = 4'(MaxBurst);

    state_e     state_q, state_d;
    logic [3:0] out_cnt_q, out_cnt_d;
    logic [3:0] burst_cnt_q, burst_cnt_d;
    logic       rr_last_q, rr_last_d;

    tl_h2d_t    host_req;
    tl_d2h_t    resp;
    logic       granted, gnt_h1, other_valid, burst_exempt, burst_limited;
    logic       accept_en, dev_a_valid, dev_d_ready, a_fire, d_fire, tie_pick_h1;

    assign granted     = (state_q != IDLE);
    assign gnt_h1      = (state_q == GNT_H1);
    assign host_req    = gnt_h1 ? tl_h1_i : tl_h0_i;
    assign other_valid = gnt_h1 ? tl_h0_i.a_valid : tl_h1_i.a_valid;

`ifdef TLUL_ARB_LSU_PRIORITY_EN
    assign burst_exempt = gnt_h1;
    assign tie_pick_h1  = 1'b1;
`else
    assign burst_exempt = 1'b0;
    assign tie_pick_h1  = !rr_last_q;
`endif

    // The burst cap only bites while the other host is actually waiting.
    assign burst_limited = granted && !burst_exempt && (MAX_BURST != 4'd0) &&
                           (burst_cnt_q >= MAX_BURST) && other_valid;
    // Uses the registered count, so a same-cycle D response unblocks A only next cycle.
    assign accept_en   = granted && (out_cnt_q < MAX_OUT) && !burst_limited;
    assign dev_a_valid = host_req.a_valid && accept_en;
    assign dev_d_ready = granted && host_req.d_ready;
    assign a_fire      = dev_a_valid && tl_dev_i.a_ready;
    assign d_fire      = tl_dev_i.d_valid && dev_d_ready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            out_cnt_q   <= 4'd0;
            burst_cnt_q <= 4'd0;
            rr_last_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            out_cnt_q   <= out_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            rr_last_q   <= rr_last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        out_cnt_d   = out_cnt_q;
        burst_cnt_d = burst_cnt_q;
        rr_last_d   = rr_last_q;
        case (state_q)
            IDLE: begin
                if (tl_h0_i.a_valid || tl_h1_i.a_valid) begin
                    if (tl_h0_i.a_valid && tl_h1_i.a_valid) begin
                        rr_last_d = tie_pick_h1;
                    end else begin
                        rr_last_d = tl_h1_i.a_valid;
                    end
                    state_d     = rr_last_d ? GNT_H1 : GNT_H0;
                    burst_cnt_d = 4'd0;
                end
            end
            GNT_H0, GNT_H1: begin
                case ({a_fire, d_fire})
                    2'b10:   out_cnt_d = out_cnt_q + 4'd1;
                    2'b01:   out_cnt_d = out_cnt_q - 4'd1;
                    default: out_cnt_d = out_cnt_q;
                endcase
                if (a_fire && (burst_cnt_q != 4'hF)) begin
                    burst_cnt_d = burst_cnt_q + 4'd1;
                end
                if ((out_cnt_d == 4'd0) && !a_fire && (!host_req.a_valid || burst_limited)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tl_dev_o         = host_req;
        tl_dev_o.a_valid = dev_a_valid;
        tl_dev_o.d_ready = dev_d_ready;
        resp             = tl_dev_i;
        resp.a_ready     = tl_dev_i.a_ready && accept_en;
        tl_h0_o          = '0;
        tl_h1_o          = '0;
        grant_o          = 2'b00;
        case (state_q)
            GNT_H0: begin
                tl_h0_o = resp;
                grant_o = 2'b01;
            end
            GNT_H1: begin
                tl_h1_o = resp;
                grant_o = 2'b10;
            end
            default: ;
        endcase
    end

`ifndef SYNTHESIS
    a_out_cnt_max: assert property (@(posedge clk_i) disable iff (rst_i)
        out_cnt_q <= MAX_OUT);
    a_out_cnt_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(d_fire && !a_fire && (out_cnt_q == 4'd0)));
    a_grant_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(grant_o));
    a_no_h0_to_h1: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == GNT_H0) |-> (state_d != GNT_H1));
    a_no_h1_to_h0: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == GNT_H1) |-> (state_d != GNT_H0));
    a_no_d_in_idle: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == IDLE) |-> !tl_dev_i.d_valid);
`endif
endmodule

// File: tb/tb_tlul_host_arb2.sv
// Directed bench for tlul_host_arb2: a per-cycle vector table plus hand-written corner sequences.
module tb_tlul_host_arb2;
    import tlul_arb2_pkg::*;

    localparam logic [31:0] H0_ADDR = 32'h1000_0000;
    localparam logic [31:0] H1_ADDR = 32'h2000_0040;
    localparam logic [31:0] RDATA   = 32'hDEAD_BEEF;
`ifdef TLUL_ARB_LSU_PRIORITY_EN
    localparam logic [1:0] TIE_GNT = 2'b10;
`else
    localparam logic [1:0] TIE_GNT = 2'b01;
`endif

    logic       clk;
    logic       rst;
    tl_h2d_t    h0_req, h1_req, dev_req;
    tl_d2h_t    h0_rsp, h1_rsp, dev_rsp;
    logic [1:0] grant;

    int checks = 0;
    int errors = 0;

    tlul_host_arb2 #(.MaxOutstanding(2), .MaxBurst(4)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .tl_h0_i  (h0_req),
        .tl_h0_o  (h0_rsp),
        .tl_h1_i  (h1_req),
        .tl_h1_o  (h1_rsp),
        .tl_dev_o (dev_req),
        .tl_dev_i (dev_rsp),
        .grant_o  (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst, h0v, h1v, ardy, dv;
        logic [1:0] gnt;
        logic       dav, h0r, h1r, h0d, h1d;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input string what,
                         input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s %s got %0h want %0h", nm, what, got, want);
        end
    endtask

    // Drives one cycle of inputs just after a rising edge and checks outputs before the next.
    task automatic cyc(input string nm, input logic r, h0v, h1v, ardy, dv,
                       input logic [1:0] gnt, input logic dav, h0r, h1r, h0d, h1d);
        rst              = r;
        h0_req.a_valid   = h0v;
        h1_req.a_valid   = h1v;
        dev_rsp.a_ready  = ardy;
        dev_rsp.d_valid  = dv;
        #3;
        check(nm, "grant", {30'd0, grant}, {30'd0, gnt});
        check(nm, "dev_a_valid", {31'd0, dev_req.a_valid}, {31'd0, dav});
        check(nm, "h0_a_ready", {31'd0, h0_rsp.a_ready}, {31'd0, h0r});
        check(nm, "h1_a_ready", {31'd0, h1_rsp.a_ready}, {31'd0, h1r});
        check(nm, "h0_d_valid", {31'd0, h0_rsp.d_valid}, {31'd0, h0d});
        check(nm, "h1_d_valid", {31'd0, h1_rsp.d_valid}, {31'd0, h1d});
        check(nm, "dev_d_ready", {31'd0, dev_req.d_ready}, {31'd0, (gnt != 2'b00)});
        if (dav) check(nm, "dev_a_address", dev_req.a_address, (gnt == 2'b10) ? H1_ADDR : H0_ADDR);
        if (h0d) check(nm, "h0_d_data", h0_rsp.d_data, RDATA);
        if (h1d) check(nm, "h1_d_data", h1_rsp.d_data, RDATA);
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, h0v, h1v, ardy, dv,
                       input logic [1:0] gnt, input logic dav, h0r, h1r, h0d, h1d);
        vecs.push_back('{r, h0v, h1v, ardy, dv, gnt, dav, h0r, h1r, h0d, h1d});
    endtask

    initial begin
        h0_req = '0;
        h1_req = '0;
        dev_rsp = '0;
        h0_req.a_opcode  = 3'd4;
        h0_req.a_address = H0_ADDR;
        h0_req.a_mask    = 4'hF;
        h0_req.d_ready   = 1'b1;
        h1_req.a_opcode  = 3'd4;
        h1_req.a_address = H1_ADDR;
        h1_req.a_mask    = 4'hF;
        h1_req.d_ready   = 1'b1;
        dev_rsp.d_opcode = 3'd1;
        dev_rsp.d_size   = 2'd2;
        dev_rsp.d_data   = RDATA;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        //  rst h0v h1v ardy dv   gnt   dav h0r h1r h0d h1d
        // single Get from h0, response one cycle after acceptance
        add(0, 1, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0);
        add(0, 1, 0, 1, 0, 2'b01, 1, 1, 0, 0, 0);
        add(0, 0, 0, 1, 1, 2'b01, 0, 1, 0, 1, 0);
        add(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
`ifndef TLUL_ARB_LSU_PRIORITY_EN
        // round-robin alternation on simultaneous requests
        add(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        add(0, 1, 1, 1, 0, 2'b00, 0, 0, 0, 0, 0);
        add(0, 1, 1, 1, 0, 2'b01, 1, 1, 0, 0, 0);
        add(0, 0, 1, 1, 1, 2'b01, 0, 1, 0, 1, 0);
        add(0, 0, 1, 1, 0, 2'b00, 0, 0, 0, 0, 0);
        add(0, 0, 1, 1, 0, 2'b10, 1, 0, 1, 0, 0);
        add(0, 0, 0, 1, 1, 2'b10, 0, 0, 1, 0, 1);
        add(0, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 2'b01, 1, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 2'b01, 1, 0, 0, 0, 0);
`endif
        for (int i = 0; i < vecs.size(); i++) begin
            cyc($sformatf("vec%0d", i), vecs[i].rst, vecs[i].h0v, vecs[i].h1v, vecs[i].ardy,
                vecs[i].dv, vecs[i].gnt, vecs[i].dav, vecs[i].h0r, vecs[i].h1r,
                vecs[i].h0d, vecs[i].h1d);
        end

        // outstanding limit: third A stalls; same-cycle D does not release it
        cyc("os_rst",   1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        cyc("os_req",   0, 1, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0);
        cyc("os_a1",    0, 1, 0, 1, 0, 2'b01, 1, 1, 0, 0, 0);
        cyc("os_a2",    0, 1, 0, 1, 0, 2'b01, 1, 1, 0, 0, 0);
        cyc("os_stall", 0, 1, 0, 1, 0, 2'b01, 0, 0, 0, 0, 0);
        cyc("os_d_same",0, 1, 0, 1, 1, 2'b01, 0, 0, 0, 1, 0);
        cyc("os_a3",    0, 1, 0, 1, 0, 2'b01, 1, 1, 0, 0, 0);
        cyc("os_d2",    0, 0, 0, 1, 1, 2'b01, 0, 0, 0, 1, 0);
        cyc("os_d3",    0, 0, 0, 1, 1, 2'b01, 0, 1, 0, 1, 0);
        cyc("os_idle",  0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);

        // simultaneous a_fire and d_fire keeps the count, so the grant is held
        cyc("sf_req",   0, 1, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0);
        cyc("sf_a1",    0, 1, 0, 1, 0, 2'b01, 1, 1, 0, 0, 0);
        cyc("sf_both",  0, 1, 0, 1, 1, 2'b01, 1, 1, 0, 1, 0);
        cyc("sf_hold",  0, 0, 0, 1, 0, 2'b01, 0, 1, 0, 0, 0);
        cyc("sf_drain", 0, 0, 0, 1, 1, 2'b01, 0, 1, 0, 1, 0);
        cyc("sf_idle",  0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);

        // burst limit: four h0 accepts while h1 waits, then one bubble, then h1
        cyc("bu_req",   0, 1, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0);
        cyc("bu_a1",    0, 1, 1, 1, 0, 2'b01, 1, 1, 0, 0, 0);
        cyc("bu_a2",    0, 1, 1, 1, 1, 2'b01, 1, 1, 0, 1, 0);
        cyc("bu_a3",    0, 1, 1, 1, 1, 2'b01, 1, 1, 0, 1, 0);
        cyc("bu_a4",    0, 1, 1, 1, 1, 2'b01, 1, 1, 0, 1, 0);
        cyc("bu_limit", 0, 1, 1, 1, 1, 2'b01, 0, 0, 0, 1, 0);
        cyc("bu_bubble",0, 1, 1, 1, 0, 2'b00, 0, 0, 0, 0, 0);
        cyc("bu_h1",    0, 1, 1, 1, 0, 2'b10, 1, 0, 1, 0, 0);
        cyc("bu_rst",   1, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0);

        // reset with two requests outstanding
        cyc("rs_req",   0, 1, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0);
        cyc("rs_a1",    0, 1, 0, 1, 0, 2'b01, 1, 1, 0, 0, 0);
        cyc("rs_a2",    0, 1, 0, 1, 0, 2'b01, 1, 1, 0, 0, 0);
        cyc("rs_rst",   1, 1, 0, 1, 0, 2'b01, 0, 0, 0, 0, 0);
        cyc("rs_after", 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        cyc("rs_tie",   0, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        cyc("rs_tie_g", 0, 1, 1, 0, 0, TIE_GNT, 1, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tlul_host_arb2.md
Name: tlul_host_arb2

Overview:
- Two-host to one-device TL-UL arbiter.
- Lets the instruction-fetch and LSU hosts share a single device port, e.g. a unified DCCM/ICCM SRAM or a peripheral reached from both hosts.
- Sits between the host ports and the periph crossbar device port.
- Grants one host at a time and holds the grant until all of that host's outstanding responses have returned, so D-channel responses always route to the correct host.

Parameters:
- MaxOutstanding, 2: maximum accepted-but-unanswered A requests per grant (1..15).
- MaxBurst, 4: maximum A requests accepted in one grant while the other host is waiting; 0 means unlimited.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous active-high reset.
- tl_h0_i  input  tl_h2d_t  host 0 (IF) request.
- tl_h0_o  output  tl_d2h_t  host 0 response.
- tl_h1_i  input  tl_h2d_t  host 1 (LSU) request.
- tl_h1_o  output  tl_d2h_t  host 1 response.
- tl_dev_o  output  tl_h2d_t  shared device request.
- tl_dev_i  input  tl_d2h_t  shared device response.
- grant_o  output  2  one-hot current grant (debug/perf); 0 when idle.

Behaviour:
- One clock, clk_i. Reset is synchronous and active-high on rst_i.
- FSM states: IDLE, GNT_H0, GNT_H1.
- Counters:
  - out_cnt: 4 bits, outstanding requests.
  - burst_cnt: 4 bits, saturating.
- rr_last: 1 bit, last-served host.
- Reset values:
  - state IDLE, out_cnt 0, burst_cnt 0, rr_last=1 (so host 0 wins the first tie), grant_o 0.
  - All a_valid/d_valid/a_ready/d_ready outputs 0.
  - Other h2d/d2h fields are don't-care while valid is 0.
- IDLE:
  - Both hosts see a_ready=0; tl_dev_o.a_valid=0; tl_dev_o.d_ready=0.
  - Only h0 a_valid -> GNT_H0. Only h1 -> GNT_H1.
  - Both -> grant the host != rr_last.
  - On every grant: rr_last <= granted host, burst_cnt <= 0.
  - First-access latency: 1 cycle from a_valid to grant; the A channel then passes through combinationally.
- GNT_Hx:
  - tl_dev_o = tl_hx_i, except a_valid is gated by accept_en.
  - tl_hx_o = tl_dev_i, except a_ready is gated by accept_en.
  - The non-granted host sees a_ready=0 and d_valid=0.
  - accept_en = (out_cnt < MaxOutstanding) && !(MaxBurst!=0 && burst_cnt>=MaxBurst && other host a_valid).
  - a_fire = dev a_valid & a_ready. d_fire = dev d_valid & d_ready.
  - out_cnt: +1 on a_fire only, -1 on d_fire only, unchanged on both.
  - burst_cnt: +1 on a_fire, saturating at 15.
  - Release to IDLE when out_cnt_next==0, no a_fire this cycle, and either host x has a_valid=0 or burst-limited.
  - A new grant is evaluated in IDLE on the following cycle (1 idle bubble per switch).
- Boundaries:
  - out_cnt==MaxOutstanding: A stalls (a_ready=0); a D response in the same cycle does not unblock A until the next cycle.
  - A d_valid arriving in IDLE (protocol error): d_ready=0, dropped from host view. Assertion required.
  - The granted host deasserting a_valid mid-burst with out_cnt>0: stay granted until drained.
  - Reset mid-transaction: immediately IDLE with counters cleared; outstanding responses are abandoned. The device must be reset in the same domain.
- Assertions:
  - out_cnt never underflows or exceeds MaxOutstanding.
  - grant_o is one-hot or zero.
  - The FSM never goes GNT_H0 -> GNT_H1 directly.

Optional Feature:
- Macro TLUL_ARB_LSU_PRIORITY_EN.
- When defined:
  - IDLE ties always grant host 1 (LSU); rr_last is ignored.
  - The MaxBurst limit applies only to host 0; host 1 may burst unlimited.
- When undefined: round-robin and the symmetric burst limit as described above.

Test Plan:
- After reset, h0 issues a Get to 0x1000_0000; device responds next cycle -> grant_o=01 one cycle after a_valid, dev a_valid same cycle as grant, h0 d_valid with data 0xDEADBEEF, return to IDLE, out_cnt=0.
- h0 and h1 assert a_valid in the same cycle after reset -> h0 granted first. After h0 drains, h1 granted next; the next tie grants h0 again (alternation).
- MaxOutstanding=2, device withholds responses -> 2 A accepted, third stalls with a_ready=0. One D returns -> third accepted next cycle.
- MaxBurst=4, h0 streams continuously while h1 waits -> exactly 4 h0 A accepted, drain, 1 idle cycle, then h1 granted.
- a_fire and d_fire in the same cycle with out_cnt=1 -> out_cnt stays 1, grant held.
- rst_i asserted with out_cnt=2 -> next cycle state IDLE, grant_o=0, all valids 0. With TLUL_ARB_LSU_PRIORITY_EN, a simultaneous request afterwards grants h1.
